div_controller: RTL and testbench
=================================

Name: div_controller

Overview:
- FSM controller for the 10-bit restoring-divider datapath.
- Accepts a divide request over a start/ready handshake and sequences operand load, divide-by-zero check and the shift/subtract iterations.
- Consumes the datapath status flags (dvz, ovf, co_counter, be) and drives its load, select and counter controls.
- Presents completion to the downstream consumer through a valid/ready handshake with a 2-bit status code; the quotient is read from the datapath while result_valid=1.

Parameters:
- MAX_ITER, 16, watchdog limit on ITER cycles before timeout abort.
- IW, 5, width of internal watchdog counter; must satisfy 2^IW > MAX_ITER.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted when start & start_ready.
- start_ready  out  1  high only in IDLE.
- result_valid  out  1  high only in DONE.
- result_ready  in  1  consumer accepts the result.
- status  out  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout; valid while result_valid=1.
- busy  out  1  high in LOAD, CHECK, ITER.
- dvz, ovf, co_counter, be  in  1 each  datapath status flags.
- sclr  out  1  datapath synchronous clear.
- ld_B, ld_Q, ld_ACC, ld_counter, increace_counter  out  1 each  datapath load/count enables.
- select_Q, select_ACC  out  2 each  datapath mux selects: 00 zero, 01 load operand, 10 subtract-and-shift, 11 shift only.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, status=00, watchdog=0.
  - Outputs during reset: sclr=1, start_ready=1; all other outputs 0.
- Mealy-gated outputs: loads in ITER depend on ovf; selects in ITER depend on be. All other outputs are a Moore decode of the state.
- IDLE:
  - sclr=1, start_ready=1.
  - On start: next state LOAD; status cleared to 00.
- LOAD, exactly 1 cycle:
  - ld_B=1, ld_ACC=1, ld_Q=1, select_ACC=01, select_Q=01, ld_counter=1.
  - Next state CHECK.
- CHECK, exactly 1 cycle, no loads:
  - dvz=1: status<=01, next state DONE.
  - Otherwise: watchdog<=0, next state ITER.
- ITER, one iteration per cycle:
  - select_ACC = select_Q = be ? 10 : 11.
  - Priority per cycle: ovf > co_counter > watchdog.
  - ovf=1: ld_ACC=ld_Q=increace_counter=0 that cycle; status<=10; next state DONE.
  - Else: ld_ACC=ld_Q=increace_counter=1.
    - co_counter=1: this is the final iteration; status<=00; next state DONE.
    - Else, watchdog==MAX_ITER-1: status<=11; next state DONE.
    - Else: watchdog++, stay in ITER.
- DONE:
  - result_valid=1, all loads 0; datapath registers hold the quotient.
  - result_ready=1: next state IDLE.
  - result_ready=0: hold state; status stable; start ignored because start_ready=0.
- start asserted in any non-IDLE state is ignored, not queued.
- result_ready outside DONE is ignored.
- Same-cycle completion and new request is not possible: the DONE→IDLE transition takes one cycle, so back-to-back throughput is 1 idle cycle between jobs.
- Reset asserted mid-operation: immediate return to IDLE. Datapath contents are don't-care; they are cleared by sclr in IDLE.
- Latency, start accepted to result_valid: 2 + N cycles, N = ITER cycles (N≥1); 2 cycles on divide-by-zero.

Decomposition:
- Shared package div_pkg:
  - State enum {IDLE, LOAD, CHECK, ITER, DONE}.
  - Select encodings SEL_ZERO, SEL_LOAD, SEL_SUB, SEL_SHIFT.
  - Status codes ST_OK, ST_DVZ, ST_OVF, ST_TMO.
- Single module; the watchdog is an inline counter. No sub-module is needed.

Test Plan:
- Normal divide: start pulse, dvz=0, be alternating 1/0, co_counter=1 on the 13th ITER cycle → exactly 13 ITER cycles with ld_ACC=ld_Q=increace_counter=1; result_valid rises on cycle 15 after start acceptance; status=00.
- Divide by zero: dvz=1 during CHECK → no ITER cycles; result_valid 2 cycles after acceptance; status=01; ld_ACC never asserted after LOAD.
- Overflow: ovf=1 on the 4th ITER cycle → that cycle ld_ACC=ld_Q=increace_counter=0; next cycle result_valid=1 with status=10. Also drive ovf=1 and co_counter=1 together → status=10.
- Select tracking: in ITER drive be=1, 0, 1 → select_ACC = select_Q = 10, 11, 10 on the matching cycles.
- Backpressure: result_ready=0 for 5 cycles, start pulsed meanwhile → result_valid and status held, start_ready=0, no new LOAD. result_ready=1 → IDLE next cycle, start_ready=1.
- Timeout and reset: MAX_ITER=16, co_counter stuck 0 → status=11 after 16 ITER cycles. Separately, drop rst_n mid-ITER between clock edges → state IDLE, sclr=1, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state, mux-select and status encodings for the divider controller
package div_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ITER, DONE} state_t;
  localparam logic [1:0] SEL_ZERO  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_SUB   = 2'b10;
  localparam logic [1:0] SEL_SHIFT = 2'b11;
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_DVZ = 2'b01;
  localparam logic [1:0] ST_OVF = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;
endpackage

// File: rtl/div_controller.sv
// div_controller: handshake FSM sequencing the restoring-divider datapath
module div_controller
  import div_pkg::*;
#(
  parameter int MAX_ITER = 16,
  parameter int IW = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       start_ready,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [1:0] status,
  output logic       busy,
  input  logic       dvz,
  input  logic       ovf,
  input  logic       co_counter,
  input  logic       be,
  output logic       sclr,
  output logic       ld_B,
  output logic       ld_Q,
  output logic       ld_ACC,
  output logic       ld_counter,
  output logic       increace_counter,
  output logic [1:0] select_Q,
  output logic [1:0] select_ACC
);
  state_t state, state_nx;
  logic [1:0] status_nx;
  logic [IW-1:0] wd, wd_nx;
  // state, status and watchdog registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      status <= ST_OK;
      wd     <= '0;
    end else begin
      state  <= state_nx;
      status <= status_nx;
      wd     <= wd_nx;
    end
  // next state and datapath controls; ITER loads gated by ovf, selects by be
  always_comb begin
    state_nx = state;
    status_nx = status;
    wd_nx = wd;
    start_ready = 1'b0;
    result_valid = 1'b0;
    busy = 1'b0;
    sclr = 1'b0;
    ld_B = 1'b0;
    ld_Q = 1'b0;
    ld_ACC = 1'b0;
    ld_counter = 1'b0;
    increace_counter = 1'b0;
    select_Q = SEL_ZERO;
    select_ACC = SEL_ZERO;
    case (state)
      IDLE: begin
        sclr = 1'b1;
        start_ready = 1'b1;
        if (start) begin
          state_nx = LOAD;
          status_nx = ST_OK;
        end
      end
      LOAD: begin
        busy = 1'b1;
        ld_B = 1'b1;
        ld_Q = 1'b1;
        ld_ACC = 1'b1;
        ld_counter = 1'b1;
        select_Q = SEL_LOAD;
        select_ACC = SEL_LOAD;
        state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        wd_nx = '0;
        state_nx = dvz ? DONE : ITER;
        status_nx = dvz ? ST_DVZ : status;
      end
      ITER: begin
        busy = 1'b1;
        select_Q = be ? SEL_SUB : SEL_SHIFT;
        select_ACC = be ? SEL_SUB : SEL_SHIFT;
        ld_Q = !ovf;
        ld_ACC = !ovf;
        increace_counter = !ovf;
        if (ovf) begin
          status_nx = ST_OVF;
          state_nx = DONE;
        end else if (co_counter) begin
          status_nx = ST_OK;
          state_nx = DONE;
        end else if (wd == IW'(MAX_ITER - 1)) begin
          status_nx = ST_TMO;
          state_nx = DONE;
        end else
          wd_nx = wd + 1'b1;
      end
      DONE: begin
        result_valid = 1'b1;
        state_nx = result_ready ? IDLE : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller: table-driven and randomized check of the divider controller
module tb_div_controller;
  localparam int MAX_ITER = 16;
  localparam int NONE = 99;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, result_ready = 1'b0;
  logic dvz = 1'b0, ovf = 1'b0, co_counter = 1'b0, be = 1'b0;
  logic start_ready, result_valid, busy, sclr, ld_B, ld_Q, ld_ACC, ld_counter, increace_counter;
  logic [1:0] status, select_Q, select_ACC;
  int passed = 0, total = 0;
  typedef struct {
    bit dz;
    int oa;
    int ca;
    int hold;
    bit [1:0] es;
    int en;
  } vec_t;
  vec_t tbl[8];
  div_controller #(.MAX_ITER(MAX_ITER), .IW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .result_valid(result_valid), .result_ready(result_ready), .status(status),
    .busy(busy), .dvz(dvz), .ovf(ovf), .co_counter(co_counter), .be(be),
    .sclr(sclr), .ld_B(ld_B), .ld_Q(ld_Q), .ld_ACC(ld_ACC), .ld_counter(ld_counter),
    .increace_counter(increace_counter), .select_Q(select_Q), .select_ACC(select_ACC)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  // Job-level reference: the first ITER cycle that ends the job decides the outcome.
  function automatic void model(input bit dz, input int oa, input int ca,
                                output bit [1:0] st, output int n);
    int e;
    if (dz) begin
      st = 2'b01;
      n = 0;
    end else begin
      e = MAX_ITER - 1;
      if (oa < e) e = oa;
      if (ca < e) e = ca;
      st = (oa == e) ? 2'b10 : (ca == e) ? 2'b00 : 2'b11;
      n = e + 1;
    end
  endfunction
  // Starts a job, drives flags by cycle offset from acceptance; abort_at>=0 pulls reset mid-cycle.
  task automatic run_job(input bit dz, input int oa, input int ca, input int hold,
                         input bit [1:0] es, input int en, input int abort_at);
    int t;
    int i;
    bit bv;
    @(negedge clk);
    start = 1'b1; dvz = 1'b0; ovf = 1'b0; co_counter = 1'b0; result_ready = 1'b0;
    #1 chk("start_ready_idle", start_ready, 1);
    t = 0;
    forever begin
      @(negedge clk);
      i = t - 2;
      bv = 1'($urandom);
      start = 1'($urandom);
      dvz = (t == 1) ? dz : 1'($urandom);
      ovf = (i == oa);
      co_counter = (i == ca);
      be = bv;
      #1;
      if (t == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_sclr", sclr, 1);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_ld_acc", ld_ACC, 0);
        chk("rst_status", status, 0);
        @(negedge clk) rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      if (result_valid || t > 60) break;
      chk("busy", busy, 1);
      chk("start_ready_busy", start_ready, 0);
      if (t == 0) begin
        chk("load_ld_b", ld_B, 1);
        chk("load_ld_counter", ld_counter, 1);
        chk("load_sel_acc", select_ACC, 1);
        chk("load_sel_q", select_Q, 1);
      end else if (t == 1) begin
        chk("check_ld_acc", ld_ACC, 0);
      end else begin
        chk("iter_ld_acc", ld_ACC, (i != oa));
        chk("iter_ld_q", ld_Q, (i != oa));
        chk("iter_inc", increace_counter, (i != oa));
        chk("iter_sel_acc", select_ACC, bv ? 2 : 3);
        chk("iter_sel_q", select_Q, bv ? 2 : 3);
      end
      t++;
    end
    chk("latency", t, 2 + en);
    chk("status", status, es);
    dvz = 1'b0; ovf = 1'b0; co_counter = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = 1'b1;
      #1;
      chk("hold_valid", result_valid, 1);
      chk("hold_status", status, es);
      chk("hold_start_ready", start_ready, 0);
      chk("hold_busy", busy, 0);
    end
    @(negedge clk);
    start = 1'b0; result_ready = 1'b1;
    #1 chk("done_valid", result_valid, 1);
    @(negedge clk);
    result_ready = 1'b0;
    #1;
    chk("idle_start_ready", start_ready, 1);
    chk("idle_valid", result_valid, 0);
    chk("idle_sclr", sclr, 1);
  endtask
  initial begin
    bit [1:0] st;
    int n;
    tbl[0] = '{0, NONE, 12, 5, 2'b00, 13};
    tbl[1] = '{1, NONE, NONE, 0, 2'b01, 0};
    tbl[2] = '{0, 3, NONE, 0, 2'b10, 4};
    tbl[3] = '{0, 5, 5, 1, 2'b10, 6};
    tbl[4] = '{0, NONE, NONE, 0, 2'b11, 16};
    tbl[5] = '{0, NONE, 0, 0, 2'b00, 1};
    tbl[6] = '{0, NONE, 15, 2, 2'b00, 16};
    tbl[7] = '{0, 15, NONE, 0, 2'b10, 16};
    #3;
    chk("reset_sclr", sclr, 1);
    chk("reset_start_ready", start_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_status", status, 0);
    chk("reset_ld_acc", ld_ACC, 0);
    @(negedge clk) rst_n = 1'b1;
    foreach (tbl[k])
      run_job(tbl[k].dz, tbl[k].oa, tbl[k].ca, tbl[k].hold, tbl[k].es, tbl[k].en, -1);
    run_job(0, NONE, NONE, 0, 2'b11, 16, 5);
    run_job(tbl[0].dz, tbl[0].oa, tbl[0].ca, 0, tbl[0].es, tbl[0].en, -1);
    for (int r = 0; r < 25; r++) begin
      bit dz;
      int oa, ca;
      dz = ($urandom_range(0, 4) == 0);
      oa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 17)) : NONE;
      ca = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 19)) : NONE;
      model(dz, oa, ca, st, n);
      run_job(dz, oa, ca, $urandom_range(0, 3), st, n, -1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
